// File: rtl/dma_addr_seq.sv
// Registered 2-D strided DMA address sequencer with optional read-modify-write,
// page-crossing stall and req/ack memory handshake. Optional element counter: DMA_ADDR_SEQ_XFER_CNT_EN.
module dma_addr_seq #(
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 8,
  parameter int PAGE_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rmw,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  x_len,
  input  logic [CNT_W-1:0]  y_len,
  input  logic [ADDR_W-1:0] x_stride,
  input  logic [ADDR_W-1:0] y_stride,
  input  logic              abort,
  input  logic              page_ack,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              page_cross,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        st
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
  ,
  output logic [2*CNT_W-1:0] xfer_cnt
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] ADV   = 3'd3;
  localparam logic [2:0] PAGE  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] row_base;
  logic [CNT_W-1:0]  xcnt;
  logic [CNT_W-1:0]  ycnt;
  logic              rmw_q;
  logic [CNT_W-1:0]  x_len_q;
  logic [CNT_W-1:0]  y_len_q;
  logic [ADDR_W-1:0] x_stride_q;
  logic [ADDR_W-1:0] y_stride_q;

  logic              row_end;
  logic              last_row;
  logic [ADDR_W-1:0] row_next;
  logic [ADDR_W-1:0] step_addr;
  logic              page_chg;

  // Advance decode: next address is either the in-row step or the next row start.
  always_comb begin
    row_end   = 1'b0;
    last_row  = 1'b0;
    row_next  = '0;
    step_addr = '0;
    page_chg  = 1'b0;
    row_end   = !(xcnt < (x_len_q - CNT_W'(1)));
    last_row  = (ycnt == (y_len_q - CNT_W'(1)));
    row_next  = row_base + y_stride_q;
    step_addr = row_end ? row_next : (addr + x_stride_q);
    page_chg  = (step_addr[ADDR_W-1:PAGE_SHIFT] != addr[ADDR_W-1:PAGE_SHIFT]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      addr       <= '0;
      row_base   <= '0;
      xcnt       <= '0;
      ycnt       <= '0;
      rmw_q      <= 1'b0;
      x_len_q    <= '0;
      y_len_q    <= '0;
      x_stride_q <= '0;
      y_stride_q <= '0;
      aborted    <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            rmw_q      <= rmw;
            x_len_q    <= x_len;
            y_len_q    <= y_len;
            x_stride_q <= x_stride;
            y_stride_q <= y_stride;
            addr       <= base_addr;
            row_base   <= base_addr;
            xcnt       <= '0;
            ycnt       <= '0;
            aborted    <= 1'b0;
            st         <= ((x_len == '0) || (y_len == '0)) ? DONE : READ;
          end
        end
        READ: begin
          if (mem_ack) st <= rmw_q ? WRITE : ADV;
        end
        WRITE: begin
          if (mem_ack) st <= ADV;
        end
        ADV: begin
          if (abort) begin
            aborted <= 1'b1;
            st      <= DONE;
          end else if (!row_end) begin
            xcnt <= xcnt + CNT_W'(1);
            addr <= step_addr;
            st   <= page_chg ? PAGE : READ;
          end else if (last_row) begin
            st <= DONE;
          end else begin
            xcnt     <= '0;
            ycnt     <= ycnt + CNT_W'(1);
            row_base <= row_next;
            addr     <= step_addr;
            st       <= page_chg ? PAGE : READ;
          end
        end
        PAGE: begin
          if (page_ack) st <= READ;
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if ((st == IDLE) && start) begin
      xfer_cnt <= '0;
    end else if ((st == READ) && mem_ack) begin
      xfer_cnt <= xfer_cnt + (2*CNT_W)'(1);
    end
  end
`endif

  assign mem_req    = (st == READ) || (st == WRITE);
  assign mem_we     = (st == WRITE);
  assign page_cross = (st == PAGE);
  assign done       = (st == DONE);
  assign busy       = (st != IDLE);
  assign mem_addr   = addr;

endmodule

// File: tb/tb_dma_addr_seq.sv
// Directed self-checking bench for dma_addr_seq: address walks, rmw, page stall,
// empty transfer, mid-transfer reset and abort with address wrap.
module tb_dma_addr_seq;

  logic        clk = 1'b0;
  logic        rst, start, rmw, abort, page_ack, mem_ack;
  logic [15:0] base_addr, x_stride, y_stride;
  logic [7:0]  x_len, y_len;
  logic        mem_req, mem_we, page_cross, busy, done, aborted;
  logic [15:0] mem_addr;
  logic [2:0]  st;
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] acc_addr[$];
  logic        acc_we[$];
  int page_cycles, page_req, page_first, done_cyc, adv_n;

  dma_addr_seq #(.ADDR_W(16), .CNT_W(8), .PAGE_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rmw(rmw),
    .base_addr(base_addr), .x_len(x_len), .y_len(y_len),
    .x_stride(x_stride), .y_stride(y_stride),
    .abort(abort), .page_ack(page_ack), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .page_cross(page_cross), .busy(busy), .done(done),
    .aborted(aborted), .st(st)
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a transfer and records every access until done; page_ack rises in the
  // page_wait-th PAGE cycle, abort is raised in the abort_adv-th ADV cycle (0 = never).
  task automatic run_xfer(input logic [15:0] b, input logic [7:0] xl, input logic [7:0] yl,
                          input logic [15:0] xs, input logic [15:0] ys, input logic r,
                          input int page_wait, input int abort_adv);
    acc_addr.delete();
    acc_we.delete();
    page_cycles = 0; page_req = 0; page_first = -1; done_cyc = 0; adv_n = 0;
    @(negedge clk);
    base_addr = b; x_len = xl; y_len = yl; x_stride = xs; y_stride = ys; rmw = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (mem_req) begin
        acc_addr.push_back(mem_addr);
        acc_we.push_back(mem_we);
      end
      if (page_cross) begin
        if (page_first < 0) page_first = acc_addr.size();
        page_cycles++;
        if (mem_req) page_req++;
      end
      page_ack = page_cross && (page_cycles >= page_wait);
      if (st == 3'd3) begin
        adv_n++;
        abort = (adv_n == abort_adv);
      end else begin
        abort = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    page_ack = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(st), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rmw = 1'b0; abort = 1'b0; page_ack = 1'b0; mem_ack = 1'b1;
    base_addr = '0; x_len = '0; y_len = '0; x_stride = '0; y_stride = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_st", 32'(st), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_flags", {28'd0, mem_we, page_cross, done, aborted}, 32'd0);
    rst = 1'b0;

    // 1: 3x2 walk, no rmw
    run_xfer(16'h0100, 8'd3, 8'd2, 16'h0001, 16'h0010, 1'b0, 1, 0);
    check("t1_count", acc_addr.size(), 32'd6);
    for (int i = 0; i < 6 && i < acc_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), 32'(acc_addr[i]), 32'h100 + 32'((i / 3) * 16 + (i % 3)));
      check($sformatf("t1_we%0d", i), 32'(acc_we[i]), 32'd0);
    end
    check("t1_done_cyc", done_cyc, 32'd13);
    check("t1_aborted", 32'(aborted), 32'd0);
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
    check("t1_xfer_cnt", 32'(xfer_cnt), 32'd6);
`endif

    // 2: same walk with rmw
    run_xfer(16'h0100, 8'd3, 8'd2, 16'h0001, 16'h0010, 1'b1, 1, 0);
    check("t2_count", acc_addr.size(), 32'd12);
    for (int i = 0; i < 12 && i < acc_addr.size(); i++) begin
      check($sformatf("t2_addr%0d", i), 32'(acc_addr[i]), 32'h100 + 32'((i / 6) * 16 + ((i / 2) % 3)));
      check($sformatf("t2_we%0d", i), 32'(acc_we[i]), 32'(i % 2));
    end
    check("t2_done_cyc", done_cyc, 32'd19);
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
    check("t2_xfer_cnt", 32'(xfer_cnt), 32'd6);
`endif

    // 3: page crossing mid-row, 3 stall cycles
    run_xfer(16'h00FE, 8'd4, 8'd1, 16'h0001, 16'h0000, 1'b0, 3, 0);
    check("t3_count", acc_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < acc_addr.size(); i++)
      check($sformatf("t3_addr%0d", i), 32'(acc_addr[i]), 32'h00FE + 32'(i));
    check("t3_page_cycles", page_cycles, 32'd3);
    check("t3_page_req", page_req, 32'd0);
    check("t3_page_pos", page_first, 32'd2);
    check("t3_done_cyc", done_cyc, 32'd12);

    // 6: wrap across 0xFFFF then abort on second ADV (y_len=2 would otherwise continue)
    run_xfer(16'hFFFF, 8'd2, 8'd2, 16'h0001, 16'h0100, 1'b0, 1, 2);
    check("t6_count", acc_addr.size(), 32'd2);
    if (acc_addr.size() >= 2) begin
      check("t6_addr0", 32'(acc_addr[0]), 32'hFFFF);
      check("t6_addr1", 32'(acc_addr[1]), 32'h0000);
    end
    check("t6_page_cycles", page_cycles, 32'd1);
    check("t6_page_pos", page_first, 32'd1);
    check("t6_done_cyc", done_cyc, 32'd6);
    check("t6_aborted", 32'(aborted), 32'd1);
`ifdef DMA_ADDR_SEQ_XFER_CNT_EN
    check("t6_xfer_cnt", 32'(xfer_cnt), 32'd2);
`endif

    // 4: empty transfer; also clears sticky aborted
    run_xfer(16'h0300, 8'd0, 8'd5, 16'h0001, 16'h0010, 1'b0, 1, 0);
    check("t4_count", acc_addr.size(), 32'd0);
    check("t4_done_cyc", done_cyc, 32'd1);
    check("t4_aborted_clr", 32'(aborted), 32'd0);

    // 5: reset during an unacknowledged READ
    mem_ack = 1'b0;
    @(negedge clk);
    base_addr = 16'h0200; x_len = 8'd2; y_len = 8'd1; x_stride = 16'h0001; rmw = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_req_before", 32'(mem_req), 32'd1);
    check("t5_st_before", 32'(st), 32'd1);
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_req_rst", 32'(mem_req), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_st_rst", 32'(st), 32'd0);
    check("t5_done_rst", 32'(done), 32'd0);
    @(negedge clk);
    check("t5_ack_ignored", 32'(st), 32'd0);
    run_xfer(16'h0200, 8'd2, 8'd1, 16'h0001, 16'h0010, 1'b0, 1, 0);
    check("t5_count", acc_addr.size(), 32'd2);
    if (acc_addr.size() >= 2) begin
      check("t5_addr0", 32'(acc_addr[0]), 32'h0200);
      check("t5_addr1", 32'(acc_addr[1]), 32'h0201);
    end
    check("t5_done_cyc", done_cyc, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
